// File: rtl/attn_value_mult.sv
// Attention output stage: O = A x V for 4x4 FP16 matrices.
// Loads V then A, then streams 16 results through a mult / add-tree / output pipeline.
module attn_value_mult #(
  parameter int sig_width       = 10,
  parameter int exp_width       = 5,
  parameter int ieee_compliance = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         V_valid,
  input  logic [sig_width+exp_width:0] V,
  input  logic                         A_valid,
  input  logic [sig_width+exp_width:0] A,
  output logic                         Out_valid,
  output logic [sig_width+exp_width:0] Out
);
  localparam int W    = sig_width + exp_width + 1;
  localparam int Bias = (1 << (exp_width - 1)) - 1;
  localparam int EMax = (1 << exp_width) - 1;

  typedef enum logic [2:0] {StIdle, StLoadV, StWaitA, StLoadA, StCalc, StOutput} state_e;

  function automatic logic [W-1:0] f_inf(input logic s);
    f_inf = {s, {exp_width{1'b1}}, {sig_width{1'b0}}};
  endfunction

  function automatic logic [W-1:0] f_invalid(input logic s);
    if (ieee_compliance != 0) f_invalid = {1'b0, {exp_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};
    else                      f_invalid = f_inf(s);
  endfunction

  // Subnormals flush to zero on input and output; exponent all-ones is infinity.
  function automatic logic [W-1:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic                     s, za, zb, ia, ib, inc;
    int                       ea, eb, e;
    logic [2*sig_width+1:0]   p;
    logic [sig_width+1:0]     mr;
    s  = a[W-1] ^ b[W-1];
    ea = int'(a[W-2:sig_width]);
    eb = int'(b[W-2:sig_width]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == EMax);
    ib = (eb == EMax);
    if ((ia && zb) || (ib && za)) fp_mul = f_invalid(s);
    else if (ia || ib)            fp_mul = f_inf(s);
    else if (za || zb)            fp_mul = {s, {(W-1){1'b0}}};
    else begin
      p = {1'b1, a[sig_width-1:0]} * {1'b1, b[sig_width-1:0]};
      e = ea + eb - Bias;
      if (p[2*sig_width+1]) e = e + 1;
      else                  p = p << 1;
      inc = p[sig_width] & ((|p[sig_width-1:0]) | p[sig_width+1]);
      mr  = {1'b0, p[2*sig_width+1:sig_width+1]} + (sig_width+2)'(inc);
      if (mr[sig_width+1]) begin
        e  = e + 1;
        mr = mr >> 1;
      end
      if (e >= EMax)  fp_mul = f_inf(s);
      else if (e <= 0) fp_mul = {s, {(W-1){1'b0}}};
      else             fp_mul = {s, e[exp_width-1:0], mr[sig_width-1:0]};
    end
  endfunction

  function automatic logic [W-1:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]         x, y;
    logic                 za, zb, ia, ib, st, inc;
    int                   ex, ey, d, e;
    logic [sig_width+3:0] mx, my, msk;
    logic [sig_width+4:0] sm;
    logic [sig_width+1:0] mr;
    za = (a[W-2:sig_width] == '0);
    zb = (b[W-2:sig_width] == '0);
    ia = (a[W-2:sig_width] == '1);
    ib = (b[W-2:sig_width] == '1);
    fp_add = '0;
    if (ia && ib && (a[W-1] != b[W-1])) fp_add = f_invalid(1'b0);
    else if (ia)       fp_add = f_inf(a[W-1]);
    else if (ib)       fp_add = f_inf(b[W-1]);
    else if (za && zb) fp_add = {a[W-1] & b[W-1], {(W-1){1'b0}}};
    else if (za)       fp_add = b;
    else if (zb)       fp_add = a;
    else begin
      if (a[W-2:0] < b[W-2:0]) begin x = b; y = a; end
      else                     begin x = a; y = b; end
      ex = int'(x[W-2:sig_width]);
      ey = int'(y[W-2:sig_width]);
      d  = ex - ey;
      mx = {1'b1, x[sig_width-1:0], 3'b000};
      my = {1'b1, y[sig_width-1:0], 3'b000};
      // Three extra bits (guard, round, sticky) keep RNE exact through alignment.
      if (d >= sig_width + 4) my = (sig_width+4)'(1);
      else begin
        msk   = ((sig_width+4)'(1) << d) - (sig_width+4)'(1);
        st    = |(my & msk);
        my    = my >> d;
        my[0] = my[0] | st;
      end
      if (x[W-1] == y[W-1]) sm = {1'b0, mx} + {1'b0, my};
      else                  sm = {1'b0, mx} - {1'b0, my};
      e = ex;
      if (sm == '0) fp_add = '0;
      else begin
        if (sm[sig_width+4]) begin
          sm = {1'b0, sm[sig_width+4:2], sm[1] | sm[0]};
          e  = e + 1;
        end else begin
          for (int k = 0; k < sig_width + 3; k++) begin
            if (!sm[sig_width+3]) begin
              sm = sm << 1;
              e  = e - 1;
            end
          end
        end
        inc = sm[2] & ((|sm[1:0]) | sm[3]);
        mr  = {1'b0, sm[sig_width+3:3]} + (sig_width+2)'(inc);
        if (mr[sig_width+1]) begin
          e  = e + 1;
          mr = mr >> 1;
        end
        if (e >= EMax)   fp_add = f_inf(x[W-1]);
        else if (e <= 0) fp_add = {x[W-1], {(W-1){1'b0}}};
        else             fp_add = {x[W-1], e[exp_width-1:0], mr[sig_width-1:0]};
      end
    end
  endfunction

  state_e         r_state, w_state_nxt;
  logic [3:0]     r_cnt;
  logic [W-1:0]   r_v [16];
  logic [W-1:0]   r_a [16];
  logic [W-1:0]   r_prod [4];
  logic           r_p_vld, r_s_vld, r_out_vld;
  logic [W-1:0]   r_sum, r_out;
  logic           w_issue;
  logic [3:0]     w_idx;
  logic [W-1:0]   w_prod [4];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (V_valid) w_state_nxt = StLoadV;
      StLoadV:  if (V_valid && r_cnt == 4'hF) w_state_nxt = StWaitA;
      StWaitA: begin
        if (V_valid)      w_state_nxt = StLoadV;
        else if (A_valid) w_state_nxt = StLoadA;
      end
      StLoadA:  if (A_valid && r_cnt == 4'hF) w_state_nxt = StCalc;
      StCalc:   w_state_nxt = StOutput;
      StOutput: if (r_cnt == 4'hF) w_state_nxt = StWaitA;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      for (int n = 0; n < 16; n++) begin
        r_v[n] <= '0;
        r_a[n] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        StIdle: if (V_valid) begin
          r_v[0] <= V;
          r_cnt  <= 4'd1;
        end
        StLoadV: if (V_valid) begin
          r_v[r_cnt] <= V;
          r_cnt      <= r_cnt + 4'd1;
        end
        StWaitA: begin
          if (V_valid) begin
            r_v[0] <= V;
            r_cnt  <= 4'd1;
          end else if (A_valid) begin
            r_a[0] <= A;
            r_cnt  <= 4'd1;
          end
        end
        StLoadA: if (A_valid) begin
          r_a[r_cnt] <= A;
          r_cnt      <= r_cnt + 4'd1;
        end
        StOutput: r_cnt <= r_cnt + 4'd1;
        default: ;
      endcase
    end
  end

  // CALC issues element 0; OUTPUT cycles 0..14 issue elements 1..15.
  assign w_issue = (r_state == StCalc) || (r_state == StOutput && r_cnt != 4'hF);
  assign w_idx   = (r_state == StCalc) ? 4'd0 : r_cnt + 4'd1;

  for (genvar gk = 0; gk < 4; gk++) begin : g_mul
    assign w_prod[gk] = fp_mul(r_a[{w_idx[3:2], 2'(gk)}], r_v[{2'(gk), w_idx[1:0]}]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) r_prod[n] <= '0;
      r_p_vld   <= 1'b0;
      r_sum     <= '0;
      r_s_vld   <= 1'b0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) r_prod[n] <= w_prod[n];
      r_p_vld   <= w_issue;
      r_sum     <= fp_add(fp_add(r_prod[0], r_prod[1]), fp_add(r_prod[2], r_prod[3]));
      r_s_vld   <= r_p_vld;
      r_out     <= r_s_vld ? r_sum : '0;
      r_out_vld <= r_s_vld;
    end
  end

  assign Out_valid = r_out_vld;
  assign Out       = r_out;
endmodule

// File: tb/tb_attn_value_mult.sv
// Table-driven bench for attn_value_mult with an output scoreboard queue.
module tb_attn_value_mult;
  logic        clk = 1'b0;
  logic        rst;
  logic        V_valid, A_valid;
  logic [15:0] V, A;
  logic        Out_valid;
  logic [15:0] Out;

  attn_value_mult #(.sig_width(10), .exp_width(5), .ieee_compliance(0)) dut (
    .clk(clk), .rst(rst), .V_valid(V_valid), .V(V), .A_valid(A_valid), .A(A),
    .Out_valid(Out_valid), .Out(Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          load_v;
    logic [15:0] vdiag;
    logic [15:0] voff;
    logic [15:0] aval;
    bit          gap;
    logic [15:0] expv;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_seen  = 0;
  int          first_cyc = 0;
  int          last_cyc  = 0;
  int          t_last  = 0;
  logic [15:0] sb [$];
  vec_t        tbl [10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (Out_valid) begin
        if (n_seen == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_seen++;
        if (sb.size() == 0) check("spurious_out_valid", {31'b0, Out_valid}, 32'd0);
        else check("out_data", {16'b0, Out}, {16'b0, sb.pop_front()});
      end else if (Out !== 16'h0000) begin
        check("out_zero_when_invalid", {16'b0, Out}, 32'd0);
      end
    end
  end

  task automatic drive(input logic vv, input logic [15:0] vd, input logic av,
                       input logic [15:0] ad);
    @(posedge clk);
    #1;
    V_valid = vv; V = vd; A_valid = av; A = ad;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic load_v(input logic [15:0] diag, input logic [15:0] off);
    for (int e = 0; e < 16; e++) begin
      logic [3:0] ee;
      ee = 4'(e);
      drive(1'b1, (ee[3:2] == ee[1:0]) ? diag : off, 1'b0, 16'h0);
    end
  endtask

  task automatic load_a(input logic [15:0] aval, input bit gap, input bit push,
                        input logic [15:0] expv);
    for (int e = 0; e < 16; e++) begin
      if (gap && e > 0) drive(1'b0, 16'h0, 1'b0, 16'h0);
      drive(1'b0, 16'h0, 1'b1, aval);
    end
    t_last = cyc + 1;
    n_seen = 0;
    if (push) for (int e = 0; e < 16; e++) sb.push_back(expv);
    drive(1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 60;
    while (sb.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    check({name, "_drained"}, sb.size(), 0);
    sb.delete();
    idle(3);
    check({name, "_count"}, n_seen, 16);
    check({name, "_latency"}, first_cyc - t_last, 3);
    check({name, "_contiguous"}, last_cyc - first_cyc, 15);
  endtask

  initial begin
    tbl[0] = '{"identity",     1'b1, 16'h3C00, 16'h0000, 16'h3400, 1'b0, 16'h3400};
    tbl[1] = '{"all_ones",     1'b1, 16'h3C00, 16'h3C00, 16'h3400, 1'b0, 16'h3C00};
    tbl[2] = '{"identity_gap", 1'b1, 16'h3C00, 16'h0000, 16'h3400, 1'b1, 16'h3400};
    tbl[3] = '{"reuse_v",      1'b0, 16'h0000, 16'h0000, 16'h3800, 1'b0, 16'h3800};
    tbl[4] = '{"diag_two",     1'b1, 16'h4000, 16'h0000, 16'h3800, 1'b0, 16'h3C00};
    tbl[5] = '{"all_two",      1'b1, 16'h4000, 16'h4000, 16'h3C00, 1'b0, 16'h4800};
    tbl[6] = '{"negative",     1'b1, 16'hBC00, 16'hBC00, 16'h3400, 1'b1, 16'hBC00};
    tbl[7] = '{"mixed_half",   1'b1, 16'h3C00, 16'h3800, 16'h3400, 1'b0, 16'h3900};
    tbl[8] = '{"cancel",       1'b1, 16'h3C00, 16'hB400, 16'h3C00, 1'b0, 16'h3400};
    tbl[9] = '{"rne_tie",      1'b1, 16'h3C00, 16'h1000, 16'h3C00, 1'b0, 16'h3C01};

    rst = 1'b1; V_valid = 1'b0; A_valid = 1'b0; V = '0; A = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, Out_valid}, 32'd0);
    check("reset_out", {16'b0, Out}, 32'd0);
    rst = 1'b0;
    idle(2);

    for (int t = 0; t < 10; t++) begin
      if (tbl[t].load_v) load_v(tbl[t].vdiag, tbl[t].voff);
      load_a(tbl[t].aval, tbl[t].gap, 1'b1, tbl[t].expv);
      wait_drain(tbl[t].name);
    end

    // Reset during the fifth output cycle.
    load_v(16'h3C00, 16'h0000);
    load_a(16'h3400, 1'b0, 1'b1, 16'h3400);
    for (int b = 0; b < 40 && n_seen < 4; b++) begin
      @(negedge clk);
      #1;
    end
    check("rst_reached_4_outputs", n_seen, 4);
    @(posedge clk);
    #2;
    check("rst_5th_present", {31'b0, Out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_out_valid_now", {31'b0, Out_valid}, 32'd0);
    check("rst_out_now", {16'b0, Out}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_a(16'h3400, 1'b0, 1'b0, 16'h0000);
    idle(25);
    check("a_without_v_ignored", n_seen, 0);
    load_v(16'h3C00, 16'h0000);
    load_a(16'h3400, 1'b0, 1'b1, 16'h3400);
    wait_drain("post_reset");

    // V and A together in WAIT_A: V wins, A sample dropped.
    drive(1'b1, 16'h3C00, 1'b1, 16'h3800);
    for (int e = 1; e < 16; e++) drive(1'b1, 16'h3C00, 1'b0, 16'h0);
    load_a(16'h3400, 1'b0, 1'b1, 16'h3C00);
    wait_drain("v_wins");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
